// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared definitions for the UART command-line parser:
//               FSM state encoding, ASCII constants, reply selection and
//               reply byte generation.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // Parser FSM states
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EXEC    = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    // Reply selected by the decoder
    typedef enum logic [1:0] {
        RPL_OK    = 2'd0,
        RPL_QUERY = 2'd1,
        RPL_ERR   = 2'd2
    } reply_t;

    // ASCII constants
    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;
    localparam logic [7:0] c_ascii_bs    = 8'h08;
    localparam logic [7:0] c_ascii_l     = 8'h4C;
    localparam logic [7:0] c_ascii_qmark = 8'h3F;
    localparam logic [7:0] c_ascii_0     = 8'h30;
    localparam logic [7:0] c_ascii_1     = 8'h31;
    localparam logic [7:0] c_ascii_o     = 8'h4F;
    localparam logic [7:0] c_ascii_k     = 8'h4B;
    localparam logic [7:0] c_ascii_e     = 8'h45;

    // Reply lengths in bytes
    localparam logic [2:0] c_len_ok    = 3'd4;
    localparam logic [2:0] c_len_query = 3'd6;
    localparam logic [2:0] c_len_err   = 3'd3;

    function automatic logic [2:0] reply_len(input reply_t sel);
        logic [2:0] len;
        case (sel)
            RPL_OK:    len = c_len_ok;
            RPL_QUERY: len = c_len_query;
            default:   len = c_len_err;
        endcase
        return len;
    endfunction

    function automatic logic [7:0] led_digit(input logic bit_val);
        return bit_val ? c_ascii_1 : c_ascii_0;
    endfunction

    // Byte number idx of the selected reply; the query reply reports led
    function automatic logic [7:0] reply_byte(input reply_t     sel,
                                              input logic [2:0] idx,
                                              input logic [2:0] led);
        logic [7:0] b;
        b = c_ascii_lf;
        case (sel)
            RPL_OK: begin
                case (idx)
                    3'd0:    b = c_ascii_o;
                    3'd1:    b = c_ascii_k;
                    3'd2:    b = c_ascii_cr;
                    default: b = c_ascii_lf;
                endcase
            end
            RPL_QUERY: begin
                case (idx)
                    3'd0:    b = c_ascii_l;
                    3'd1:    b = led_digit(led[2]);
                    3'd2:    b = led_digit(led[1]);
                    3'd3:    b = led_digit(led[0]);
                    3'd4:    b = c_ascii_cr;
                    default: b = c_ascii_lf;
                endcase
            end
            default: begin
                case (idx)
                    3'd0:    b = c_ascii_e;
                    3'd1:    b = c_ascii_cr;
                    default: b = c_ascii_lf;
                endcase
            end
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_txfifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_txfifo
// Description : First-word fall-through byte FIFO feeding the UART TX path.
//               A push is accepted only while not full (checked before any
//               same-cycle pop); push+pop on a non-empty FIFO keeps the count.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_push/i_push_data - write request and byte
//               i_pop              - read request (head is o_pop_data)
//               o_full/o_empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_txfifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_pop_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full     = (r_count == c_depth);
    assign o_empty    = (r_count == '0);
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are log2(DEPTH) wide so they wrap naturally
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Collects received bytes into a line buffer, decodes the line
//               on CR ("Lddd" sets the LEDs, "?" queries them), and streams
//               an ASCII reply into a TX FIFO.
//               Build option: define CMD_ECHO_EN to echo every accepted byte
//               (except LF) into the TX FIFO; rx_ready then also waits for
//               FIFO space.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               rx_valid/rx_ready/rx_data - received byte stream
//               tx_valid/tx_ready/tx_data - reply byte stream (FWFT)
//               led                 - LED state, led[2] is the first digit
//               busy                - high while executing or replying
//               err_pulse           - one cycle when an error reply is queued
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int LINE_MAX  = 16,
    parameter int TXF_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic [2:0] led,
    output logic       busy,
    output logic       err_pulse
);

    localparam int CW = $clog2(LINE_MAX + 1);
    localparam logic [CW-1:0] c_line_max = CW'(LINE_MAX);

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_buf [LINE_MAX];
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [2:0]    r_led;
    reply_t        r_reply_sel;
    logic [2:0]    r_reply_idx;

    logic       w_rx_fire;
    logic       w_is_cr;
    logic       w_is_lf;
    logic       w_is_bs;
    logic       w_store;
    logic       w_push;
    logic [7:0] w_push_data;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_err_pulse;
    logic       w_digits_ok;
    logic       w_dec_none;
    reply_t     w_dec_sel;
    logic [2:0] w_new_led;

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
`ifdef CMD_ECHO_EN
    // Every echoed byte needs a FIFO slot, so hold off the sender when full
    assign rx_ready = (r_state == ST_COLLECT) && !w_fifo_full;
`else
    assign rx_ready = (r_state == ST_COLLECT);
`endif

    assign w_rx_fire = rx_valid && rx_ready;
    assign w_is_cr   = (rx_data == c_ascii_cr);
    assign w_is_lf   = (rx_data == c_ascii_lf);
    assign w_is_bs   = (rx_data == c_ascii_bs);
    assign w_store   = w_rx_fire && !w_is_cr && !w_is_lf && !w_is_bs
                       && (r_count < c_line_max);

    // ------------------------------------------------------------------
    // Line decode (meaningful in EXEC)
    // ------------------------------------------------------------------
    assign w_digits_ok = ((r_buf[1] == c_ascii_0) || (r_buf[1] == c_ascii_1)) &&
                         ((r_buf[2] == c_ascii_0) || (r_buf[2] == c_ascii_1)) &&
                         ((r_buf[3] == c_ascii_0) || (r_buf[3] == c_ascii_1));
    // ASCII '0'/'1' differ only in bit 0
    assign w_new_led   = {r_buf[1][0], r_buf[2][0], r_buf[3][0]};
    assign w_dec_none  = (r_count == '0) && !r_ovf;

    always_comb begin
        w_dec_sel = RPL_ERR;
        if (r_ovf) begin
            w_dec_sel = RPL_ERR;
        end else if ((r_count == CW'(4)) && (r_buf[0] == c_ascii_l) && w_digits_ok) begin
            w_dec_sel = RPL_OK;
        end else if ((r_count == CW'(1)) && (r_buf[0] == c_ascii_qmark)) begin
            w_dec_sel = RPL_QUERY;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_COLLECT;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_push_data  = 8'h00;
        w_err_pulse  = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (w_rx_fire) begin
`ifdef CMD_ECHO_EN
                    if (!w_is_lf) begin
                        w_push      = 1'b1;
                        w_push_data = rx_data;
                    end
`endif
                    if (w_is_cr) w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_err_pulse  = !w_dec_none && (w_dec_sel == RPL_ERR);
                w_state_next = w_dec_none ? ST_COLLECT : ST_RESP;
            end
            ST_RESP: begin
                w_push_data = reply_byte(r_reply_sel, r_reply_idx, r_led);
                if (!w_fifo_full) begin
                    w_push = 1'b1;
                    if (r_reply_idx == reply_len(r_reply_sel) - 3'd1)
                        w_state_next = ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_led       <= 3'b000;
            r_reply_sel <= RPL_OK;
            r_reply_idx <= 3'd0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_rx_fire && !w_is_cr && !w_is_lf) begin
                        if (w_is_bs) begin
                            if (r_count != '0) r_count <= r_count - CW'(1);
                        end else if (r_count < c_line_max) begin
                            r_count <= r_count + CW'(1);
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    r_count     <= '0;
                    r_ovf       <= 1'b0;
                    r_reply_sel <= w_dec_sel;
                    r_reply_idx <= 3'd0;
                    if (!w_dec_none && (w_dec_sel == RPL_OK)) r_led <= w_new_led;
                end
                ST_RESP: begin
                    if (w_push) r_reply_idx <= r_reply_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Line buffer: written at the current count, no reset needed
    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int i = 0; i < LINE_MAX; i++) begin
                if (r_count == CW'(i)) r_buf[i] <= rx_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    uart_cmd_txfifo #(
        .DEPTH (TXF_DEPTH)
    ) u_txfifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (tx_valid && tx_ready),
        .o_pop_data  (tx_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign tx_valid  = !w_fifo_empty;
    assign led       = r_led;
    assign busy      = (r_state != ST_COLLECT);
    assign err_pulse = w_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Directed self-checking bench for uart_cmd_parser.
//               Inputs change 1 time unit after the rising edge; outputs and
//               handshakes are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

`ifdef CMD_ECHO_EN
    localparam bit c_echo = 1'b1;
`else
    localparam bit c_echo = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [2:0] led;
    logic       busy;
    logic       err_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    logic [7:0] tx_q[$];

    always #15 clk = ~clk;

    uart_cmd_parser #(
        .LINE_MAX  (16),
        .TXF_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .led       (led),
        .busy      (busy),
        .err_pulse (err_pulse)
    );

    // Transmitted-byte and error-pulse monitors
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (!rst && err_pulse) err_cnt++;
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic string echo_of(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++)
            if (c_echo && s[i] != 8'h0A) r = {r, s.substr(i, i)};
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int w;
        w        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) check_value("rx_accept_timeout", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || tx_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_value({tag, "_timeout"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_tx(input string tag, input string exp);
        check_value({tag, "_len"}, tx_q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < tx_q.size(); i++)
            check_value($sformatf("%s_b%0d", tag, i), {24'd0, tx_q[i]}, {24'd0, exp[i]});
        tx_q.delete();
    endtask

    initial begin
        string cmds [4];
        string s;
        int    e0;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check_value("rst_tx_valid",  {31'd0, tx_valid},  32'd0);
        check_value("rst_rx_ready",  {31'd0, rx_ready},  32'd1);
        check_value("rst_led",       {29'd0, led},       32'd0);
        check_value("rst_busy",      {31'd0, busy},      32'd0);
        check_value("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // LED set: led changes exactly at the EXEC edge
        send_str("L101\r");
        check_value("set_exec_busy", {31'd0, busy},      32'd1);
        check_value("set_exec_err",  {31'd0, err_pulse}, 32'd0);
        check_value("set_led_pre",   {29'd0, led},       32'd0);
        @(posedge clk);
        #1;
        check_value("set_led_post",  {29'd0, led},       32'b101);
        wait_done("set");
        check_tx("set_tx", {echo_of("L101\r"), "OK\r\n"});
        check_value("set_no_err", err_cnt, 32'd0);

        // Query
        send_str("?\r");
        wait_done("qry");
        check_tx("qry_tx", {echo_of("?\r"), "L101\r\n"});

        // Malformed commands, including lowercase
        cmds = '{"X\r", "L12\r", "L1011\r", "l101\r"};
        for (int k = 0; k < 4; k++) begin
            e0 = err_cnt;
            send_str(cmds[k]);
            check_value($sformatf("err%0d_pulse", k), {31'd0, err_pulse}, 32'd1);
            wait_done("err");
            check_tx($sformatf("err%0d_tx", k), {echo_of(cmds[k]), "E\r\n"});
            check_value($sformatf("err%0d_cnt", k), err_cnt, e0 + 1);
            check_value($sformatf("err%0d_led", k), {29'd0, led}, 32'b101);
        end

        // Line overflow, then an empty line must produce nothing
        s = "";
        repeat (20) s = {s, "A"};
        s  = {s, "\r"};
        e0 = err_cnt;
        send_str(s);
        wait_done("ovf");
        check_tx("ovf_tx", {echo_of(s), "E\r\n"});
        check_value("ovf_cnt", err_cnt, e0 + 1);
        send_str("\r");
        repeat (10) @(posedge clk);
        #1;
        check_tx("empty_tx", echo_of("\r"));
        check_value("empty_busy", {31'd0, busy}, 32'd0);
        check_value("empty_err", err_cnt, e0 + 1);

        // Backspace editing with the TX side stalled
        tx_ready = 1'b0;
        s = {"L10", "\010", "00\r"};
        send_str(s);
        check_value("bs_rx_ready_exec", {31'd0, rx_ready}, 32'd0);
        check_value("bs_busy_exec",     {31'd0, busy},     32'd1);
        repeat (50) @(posedge clk);
        #1;
        check_value("bs_tx_valid", {31'd0, tx_valid}, 32'd1);
        check_value("bs_head", {24'd0, tx_data}, c_echo ? 32'h4C : 32'h4F);
        check_value("bs_led", {29'd0, led}, 32'b100);
        tx_ready = 1'b1;
        wait_done("bs");
        check_tx("bs_tx", {echo_of(s), "OK\r\n"});

`ifndef CMD_ECHO_EN
        // Two queries into an 8-deep FIFO: the second reply stalls on full
        tx_ready = 1'b0;
        send_str("?\r");
        send_str("?\r");
        repeat (30) @(posedge clk);
        #1;
        check_value("full_busy",     {31'd0, busy},     32'd1);
        check_value("full_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_value("full_head",     {24'd0, tx_data},  32'h4C);
        tx_ready = 1'b1;
        wait_done("full");
        check_tx("full_tx", "L100\r\nL100\r\n");
`endif

        // Reset in the middle of a query reply
        tx_ready = 1'b0;
        send_str("?\r");
        repeat (2) @(posedge clk);
        #1;
        check_value("mid_tx_valid", {31'd0, tx_valid}, 32'd1);
        check_value("mid_busy",     {31'd0, busy},     32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_value("rstm_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_value("rstm_led",      {29'd0, led},      32'd0);
        check_value("rstm_rx_ready", {31'd0, rx_ready}, 32'd1);
        check_value("rstm_busy",     {31'd0, busy},     32'd0);
        rst      = 1'b0;
        tx_ready = 1'b1;
        tx_q.delete();
        @(posedge clk);
        #1;
        send_str("?\r");
        wait_done("post");
        check_tx("post_tx", {echo_of("?\r"), "L000\r\n"});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
